noc_output_arbiter: RTL and testbench

NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

---
 rtl/noc_output_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_noc_output_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// Purpose : 4:1 round-robin NoC output-port arbiter; holds one requester for a whole packet (head..eop).
// Latency : 2 cycles from request to a head flit on out_flit (grant, then register); 1 cycle per body flit.
// Backpress: a one-deep output register; the granted in_ready drops while out_valid && !out_ready.
//
// Ports:
//   clk, reset_n         sole clock; asynchronous active-low reset
//   in_valid/in_flit     four requesters, flit i at in_flit[13i+12:13i] = {dest,package_type,payload,eop}
//   in_ready             per-requester accept, only ever set for the locked requester
//   out_valid/out_flit   registered output flit; out_ready is the downstream accept
//   grant_id, busy       locked requester index (meaningful while busy) and LOCK state indicator
//   pkt_count            per-requester saturating eop counters, present only with NOC_ARB_STATS_EN
//
// Build option: define NOC_ARB_STATS_EN to add the pkt_count output and its counters.

module noc_output_arbiter #(
  parameter logic [1:0]  PORT_ID = 2'b00,
  parameter int unsigned STAT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          in_valid,
  input  logic [51:0]         in_flit,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [12:0]         out_flit,
  input  logic                out_ready,
  output logic [1:0]          grant_id,
  output logic                busy
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [4*STAT_W-1:0] pkt_count
`endif
);

  typedef struct packed {
    logic [1:0] dest;
    logic [1:0] package_type;
    logic [7:0] payload;
    logic       eop;
  } flit_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0] state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] grant_q, grant_d;
  logic       out_valid_q, out_valid_d;
  flit_t      out_flit_q, out_flit_d;

  flit_t      flit_in [4];
  logic [3:0] elig;
  logic [1:0] pick;
  logic       pick_vld;
  logic [1:0] scan_idx;
  logic       lock;
  logic       out_space;
  logic       accept;
  logic       eop_accept;
  flit_t      grant_flit;

  // Unpack the flat input bus and qualify each request by destination.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      flit_in[i] = in_flit[13*i +: 13];
      elig[i]    = in_valid[i] && (flit_in[i].dest == PORT_ID);
    end
  end

  // Round-robin search: scanning offsets from high to low lets the lowest
  // offset from rr_ptr overwrite the others, so it wins.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    scan_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (elig[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign lock       = (state_q == ST_LOCK);
  assign out_space  = !out_valid_q || out_ready;
  assign grant_flit = flit_in[grant_q];
  // elig already contains in_valid, so this is exactly in_valid && in_ready
  // for the granted requester.
  assign accept     = lock && elig[grant_q] && out_space;
  assign eop_accept = accept && grant_flit.eop;

  // Only the locked requester is ever offered a slot, and only when the
  // output register is empty or draining this cycle.
  always_comb begin
    in_ready = 4'b0000;
    if (lock && out_space) begin
      in_ready[grant_q] = elig[grant_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_LOCK;
          grant_d = pick;
        end
      end
      ST_LOCK: begin
        // Lock is held through body flits and through bubbles where the
        // owner drops in_valid; only its eop releases the output.
        if (eop_accept) begin
          state_d  = ST_IDLE;
          rr_ptr_d = grant_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-deep output stage: load on accept, otherwise empty on a downstream
  // transfer, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_flit_d  = grant_flit;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 2'd0;
      grant_q     <= 2'd0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign grant_id  = grant_q;
  assign busy      = lock;

`ifdef NOC_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [4];
  logic [STAT_W-1:0] cnt_d [4];

  // Completed packets per requester, sticking at all-ones.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (eop_accept && (grant_q == 2'(i)) && (cnt_q[i] != {STAT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pkt_count
    assign pkt_count[STAT_W*g +: STAT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
`timescale 1ns/1ps
module tb_noc_output_arbiter;

  localparam logic [1:0] PID = 2'b00;
  localparam int SW = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  in_valid;
  logic [51:0] in_flit;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [12:0] out_flit;
  logic        out_ready;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef NOC_ARB_STATS_EN
  logic [4*SW-1:0] pkt_count;
`endif

  always #5 clk = ~clk;

  noc_output_arbiter #(.PORT_ID(PID), .STAT_W(SW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef NOC_ARB_STATS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Per-requester packet sources and the observed downstream stream.
  logic [12:0] mem [4][64];
  int          wr [4];
  int          rd [4];
  bit          hold [4];
  logic [12:0] olog [$];

  // Reference model: packet-level arbitration with a one-slot output buffer.
  bit          m_lock;
  int          m_owner;
  int          m_ptr;
  bit          m_ov;
  logic [12:0] m_of;
  int          m_cnt [4];

  function automatic logic [12:0] mk(input logic [1:0] d, input logic [1:0] t,
                                     input logic [7:0] p, input logic e);
    return {d, t, p, e};
  endfunction

  function automatic bit m_elig(input int i);
    logic [12:0] f;
    f = in_flit[13*i +: 13];
    return in_valid[i] && (f[12:11] == PID);
  endfunction

  task automatic clear_bench();
    for (int i = 0; i < 4; i++) begin
      wr[i] = 0; rd[i] = 0; hold[i] = 0; m_cnt[i] = 0;
    end
    olog.delete();
    m_lock = 0; m_owner = 0; m_ptr = 0; m_ov = 0; m_of = '0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 4'b0;
    in_flit   = '0;
    out_ready = 1'b0;
    clear_bench();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // One clock: drive, compare the DUT against the model, advance the model.
  task automatic step(input bit ordy, input int vpct);
    bit rdy_exp [4];
    bit found;
    int took;
    for (int i = 0; i < 4; i++) begin
      if (!hold[i] && rd[i] < wr[i] && $urandom_range(0, 99) < vpct) hold[i] = 1;
      in_valid[i] = hold[i];
      in_flit[13*i +: 13] = hold[i] ? mem[i][rd[i]] : 13'($urandom);
    end
    out_ready = ordy;
    #1;
    for (int i = 0; i < 4; i++)
      rdy_exp[i] = m_lock && (m_owner == i) && m_elig(i) && (!m_ov || ordy);

    checks++;
    if (out_valid !== m_ov) begin
      failures++; $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, m_ov);
    end
    if (m_ov) begin
      checks++;
      if (out_flit !== m_of) begin
        failures++; $display("FAIL out_flit t=%0t got=%h exp=%h", $time, out_flit, m_of);
      end
    end
    checks++;
    if (busy !== m_lock) begin
      failures++; $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, m_lock);
    end
    if (m_lock) begin
      checks++;
      if (grant_id !== 2'(m_owner)) begin
        failures++; $display("FAIL grant_id t=%0t got=%0d exp=%0d", $time, grant_id, m_owner);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (in_valid[i]) begin
        checks++;
        if (in_ready[i] !== rdy_exp[i]) begin
          failures++; $display("FAIL in_ready[%0d] t=%0t got=%b exp=%b", i, $time, in_ready[i], rdy_exp[i]);
        end
      end
    end
`ifdef NOC_ARB_STATS_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pkt_count[SW*i +: SW] !== SW'(m_cnt[i])) begin
        failures++; $display("FAIL pkt_count[%0d] got=%0d exp=%0d", i, pkt_count[SW*i +: SW], m_cnt[i]);
      end
    end
`endif
    if (out_valid && ordy) olog.push_back(out_flit);

    // Advance the model using the same pre-edge inputs.
    if (!m_lock) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && m_elig((m_ptr + k) % 4)) begin
          found = 1; m_lock = 1; m_owner = (m_ptr + k) % 4;
        end
      end
      if (ordy) m_ov = 0;
    end else if (rdy_exp[m_owner]) begin
      took = m_owner;
      m_ov = 1;
      m_of = mem[took][rd[took]];
      hold[took] = 0;
      rd[took]++;
      if (m_of[0]) begin
        m_lock = 0;
        m_ptr = (took + 1) % 4;
        if (m_cnt[took] < (1 << SW) - 1) m_cnt[took]++;
      end
    end else if (ordy) begin
      m_ov = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 4'hF;
    in_flit  = {4{mk(PID, 2'b00, 8'h3C, 1'b1)}};
    out_ready = 1'b1;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 4'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
    checks++; if (out_flit !== 13'h0) begin failures++; $display("FAIL rst_out_flit got=%h exp=0000", out_flit); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
`ifdef NOC_ARB_STATS_EN
    checks++; if (pkt_count !== '0) begin failures++; $display("FAIL rst_pkt_count got=%h exp=0", pkt_count); end
`endif
    do_reset();
  endtask

  task automatic test_single_flit();
    int first;
    int busy_cyc;
    logic [12:0] fflit;
    do_reset();
    mem[0][0] = mk(2'b00, 2'b00, 8'hA5, 1'b1); wr[0] = 1;
    first = -1; busy_cyc = 0; fflit = '0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 100);
      if (busy) busy_cyc++;
      if (out_valid && first < 0) begin first = c + 1; fflit = out_flit; end
    end
    checks++; if (first !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", first); end
    checks++; if (fflit !== 13'h014B) begin failures++; $display("FAIL single_flit got=%h exp=014b", fflit); end
    checks++; if (busy_cyc !== 1) begin failures++; $display("FAIL single_busy_pulse got=%0d exp=1", busy_cyc); end
    // rr_ptr now points at 1: requester 1 must beat requester 0.
    mem[0][1] = mk(2'b00, 2'b01, 8'h11, 1'b1); wr[0] = 2;
    mem[1][0] = mk(2'b00, 2'b10, 8'h22, 1'b1); wr[1] = 1;
    for (int c = 0; c < 20 && olog.size() < 3; c++) step(1'b1, 100);
    checks++;
    if (olog.size() !== 3) begin
      failures++; $display("FAIL rrptr_count got=%0d exp=3", olog.size());
    end else begin
      checks++; if (olog[1] !== mem[1][0]) begin failures++; $display("FAIL rrptr_first got=%h exp=%h", olog[1], mem[1][0]); end
      checks++; if (olog[2] !== mem[0][1]) begin failures++; $display("FAIL rrptr_second got=%h exp=%h", olog[2], mem[0][1]); end
    end
  endtask

  task automatic test_burst_lock();
    logic [12:0] exp [4];
    do_reset();
    mem[1][0] = mk(2'b00, 2'b01, 8'h5A, 1'b0);
    mem[1][1] = mk(2'b00, 2'b01, 8'hFF, 1'b0);
    mem[1][2] = mk(2'b00, 2'b01, 8'h00, 1'b1);
    wr[1] = 3;
    mem[2][0] = mk(2'b00, 2'b11, 8'h77, 1'b1); wr[2] = 1;
    exp[0] = mem[1][0]; exp[1] = mem[1][1]; exp[2] = mem[1][2]; exp[3] = mem[2][0];
    for (int c = 0; c < 30 && olog.size() < 4; c++) step(1'b1, 100);
    checks++;
    if (olog.size() !== 4) begin
      failures++; $display("FAIL burst_count got=%0d exp=4", olog.size());
    end else begin
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (olog[n] !== exp[n]) begin failures++; $display("FAIL burst_order[%0d] got=%h exp=%h", n, olog[n], exp[n]); end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 2; j++) mem[r][j] = mk(2'b00, 2'(r), {2'(r), 6'(j)}, 1'b1);
      wr[r] = 2;
    end
    for (int c = 0; c < 60 && olog.size() < 8; c++) step(1'b1, 100);
    checks++;
    if (olog.size() !== 8) begin
      failures++; $display("FAIL rr_count got=%0d exp=8", olog.size());
    end else begin
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (olog[n] !== mem[n % 4][n / 4]) begin
          failures++; $display("FAIL rr_order[%0d] got=%h exp=%h", n, olog[n], mem[n % 4][n / 4]);
        end
      end
    end
  endtask

  task automatic test_ineligible();
    do_reset();
    mem[3][0] = mk(2'b01, 2'b00, 8'hC3, 1'b1); wr[3] = 1;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 100);
      checks++; if (in_ready[3] !== 1'b0) begin failures++; $display("FAIL inelig_ready c=%0d got=%b exp=0", c, in_ready[3]); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL inelig_busy c=%0d got=%b exp=0", c, busy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL inelig_out_valid c=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] held;
    do_reset();
    for (int j = 0; j < 6; j++) mem[0][j] = mk(2'b00, 2'b10, 8'h30 + 8'(j), (j == 5));
    wr[0] = 6;
    for (int c = 0; c < 3; c++) step(1'b1, 100);
    held = out_flit;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 100);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c=%0d got=%b exp=1", c, out_valid); end
      checks++; if (out_flit !== held) begin failures++; $display("FAIL stall_flit c=%0d got=%h exp=%h", c, out_flit, held); end
      checks++; if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL stall_ready c=%0d got=%b exp=0", c, in_ready[0]); end
    end
    for (int c = 0; c < 30 && olog.size() < 6; c++) step(1'b1, 100);
    checks++;
    if (olog.size() !== 6) begin
      failures++; $display("FAIL bp_count got=%0d exp=6", olog.size());
    end else begin
      for (int n = 0; n < 6; n++) begin
        checks++;
        if (olog[n] !== mem[0][n]) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", n, olog[n], mem[0][n]); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    // A finished single flit moves rr_ptr to 3 before the burst starts.
    mem[2][0] = mk(2'b00, 2'b00, 8'h01, 1'b1);
    for (int j = 1; j < 5; j++) mem[2][j] = mk(2'b00, 2'b00, 8'h40 + 8'(j), (j == 4));
    wr[2] = 5;
    for (int c = 0; c < 5; c++) step(1'b1, 100);
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
`ifdef NOC_ARB_STATS_EN
    checks++; if (pkt_count !== '0) begin failures++; $display("FAIL midrst_pkt_count got=%h exp=0", pkt_count); end
`endif
    do_reset();
    mem[3][0] = mk(2'b00, 2'b01, 8'h33, 1'b1); wr[3] = 1;
    mem[1][0] = mk(2'b00, 2'b01, 8'h11, 1'b1); wr[1] = 1;
    for (int c = 0; c < 20 && olog.size() < 2; c++) step(1'b1, 100);
    checks++;
    if (olog.size() !== 2) begin
      failures++; $display("FAIL midrst_count got=%0d exp=2", olog.size());
    end else begin
      checks++; if (olog[0] !== mem[1][0]) begin failures++; $display("FAIL midrst_first got=%h exp=%h", olog[0], mem[1][0]); end
    end
  endtask

  task automatic test_random();
    int total;
    int len;
    do_reset();
    total = 0;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 4; p++) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          mem[r][wr[r]] = mk(PID, 2'($urandom), 8'($urandom), (j == len - 1));
          wr[r]++;
        end
        total += len;
      end
    end
    for (int c = 0; c < 3000 && olog.size() < total; c++)
      step($urandom_range(0, 99) < 70, 60);
    checks++;
    if (olog.size() !== total) begin
      failures++; $display("FAIL random_drain got=%0d exp=%0d", olog.size(), total);
    end
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_burst_lock();
    test_round_robin();
    test_ineligible();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
